// File: rtl/bram_scanout_reader.sv
// Scans one framebuffer bank out of BRAM as a valid/ready bit stream.
// Ports: clk/reset, start/frame_bank/busy/done, bram_ce/block/addr/data, pix_*.
module bram_scanout_reader #(
  parameter int FRAME_BITS   = 32768,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_bank,
  output logic        busy,
  output logic        done,
  output logic [1:0]  bram_ce,
  output logic [2:0]  bram_block,
  output logic [13:0] bram_addr,
  input  logic [1:0]  bram_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic        pix_last
);

  localparam int DEPTH = READ_LATENCY + 2;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;
  localparam logic [16:0] LAST_IDX = 17'(FRAME_BITS - 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t state;
  logic bank;
  logic [16:0] cnt;
  logic [READ_LATENCY-1:0] tok_v;
  logic [READ_LATENCY-1:0] tok_l;
  logic [DEPTH-1:0] fifo_d;
  logic [DEPTH-1:0] fifo_l;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] inflight;
  logic issue;
  logic push;
  logic pop;

  // Credit: reads in flight plus buffered bits never exceed FIFO depth,
  // so a token always finds room when it exits the latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(tok_v[i]);
    end
  end

  assign issue = (state == FETCH) &&
                 ((inflight + fifo_cnt) < CW'(DEPTH));
  assign push = tok_v[READ_LATENCY-1];
  assign pop = pix_valid & pix_ready;

  assign bram_block = cnt[16:14];
  assign bram_addr = cnt[13:0];
  assign pix_valid = (fifo_cnt != '0);
  assign pix_data = pix_valid & fifo_d[rd_ptr];
  assign pix_last = pix_valid & fifo_l[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bank <= 1'b0;
      cnt <= '0;
      tok_v <= '0;
      tok_l <= '0;
      fifo_d <= '0;
      fifo_l <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bram_ce <= 2'b00;
    end else begin
      done <= 1'b0;

      tok_v[0] <= issue;
      tok_l[0] <= issue && (cnt == LAST_IDX);
      for (int i = 1; i < READ_LATENCY; i++) begin
        tok_v[i] <= tok_v[i-1];
        tok_l[i] <= tok_l[i-1];
      end

      if (push) begin
        fifo_d[wr_ptr] <= bram_data[bank];
        fifo_l[wr_ptr] <= tok_l[READ_LATENCY-1];
        wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);

      if (issue) begin
        cnt <= cnt + 17'd1;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            bank <= frame_bank;
            cnt <= '0;
            busy <= 1'b1;
            bram_ce <= frame_bank ? 2'b10 : 2'b01;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (issue && (cnt == LAST_IDX)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && pix_last) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            bram_ce <= 2'b00;
            cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bram_scanout_reader.md
# bram_scanout_reader

Read-side sequencer for the dual-port framebuffer BRAM: on a start pulse it walks one bank of 1-bit-wide BRAM blocks from block 0 / address 0 up to FRAME_BITS-1. It absorbs the fixed BRAM read latency and emits the frame as a valid/ready serial bit stream toward the display serializer. The writer side fills the other bank meanwhile (double-buffered by bank).

## Interface
- FRAME_BITS, 32768: bits per frame; range 1..131072 (8 blocks x 16384).
- READ_LATENCY, 2: cycles from address/CE to valid bram_data (pipelined read mode = 2).
- clk  in  1  sole clock; BRAM read port runs on this clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to scan a frame; ignored while busy.
- frame_bank  in  1  bank to scan; sampled only when start is accepted.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last bit is accepted.
- bram_ce  out  2  one-hot CE per bank; latched bank held high for the whole busy period.
- bram_block  out  3  BRAM block select = counter[16:14].
- bram_addr  out  14  bit address within block = counter[13:0].
- bram_data  in  2  read data, one bit per bank; the latched bank is used.
- pix_valid  out  1  pix_data/pix_last valid.
- pix_ready  in  1  sink accepts; handshake = pix_valid & pix_ready.
- pix_data  out  1  frame bit.
- pix_last  out  1  marks the bit at index FRAME_BITS-1.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: start=1 -> latch frame_bank, clear the 17-bit read counter, go to FETCH.
- FETCH: issue one read per cycle when inflight + fifo_count < DEPTH, where DEPTH = READ_LATENCY+2.
  - An issue presents the current counter on bram_block/bram_addr, pushes a token into a READ_LATENCY-deep token shift register, and increments the counter.
  - After issuing index FRAME_BITS-1, go to DRAIN.
  - With no issue, the address holds.
- DRAIN: no new issues. When the last bit handshakes, go to IDLE.
- Token exit: when a token leaves the shift register, the selected bram_data bit is written into the output FIFO (DEPTH entries), tagged last if its index = FRAME_BITS-1.
- The credit rule guarantees the FIFO never overflows. There is no drop path and none is allowed.
- bram_ce stays asserted while busy whether or not a read issues, so the pipelined output register always advances. Only tokens determine captured bits.
- Output: pix_valid = FIFO non-empty. pix_data/pix_last show the FIFO head. On handshake the head is popped.
- Simultaneous FIFO push and pop in one cycle is supported; the count is unchanged.
- start while busy: ignored; frame_bank is not re-sampled.
- FRAME_BITS=1: a single issue, then DRAIN.
- Reset mid-frame: state IDLE, FIFO and tokens flushed, counter cleared. The in-flight frame is abandoned and no done pulse is produced.

## Timing
- Reset values: busy 0, done 0, pix_valid 0, pix_data 0, pix_last 0, bram_ce 00, bram_block 0, bram_addr 0.
- Start sampled at edge E0. From E0+1: busy=1, bram_ce set, address 0 presented.
- bram_data for a read issued in cycle n is captured at the end of cycle n+READ_LATENCY. pix_valid is high from cycle n+READ_LATENCY+1.
- First pix_valid is 2+READ_LATENCY cycles after the start edge (4 with the default).
- With pix_ready held high: one bit per clock, no bubbles.
- After pix_ready deasserts, at most DEPTH bits are buffered/in flight. Issue resumes the cycle after a pop frees a credit.
- Last handshake at edge Ek: at Ek+1, busy=0, done=1 (one cycle), bram_ce=00. A start at Ek+1 is accepted.
- Address wrap: counter 16383 -> 16384 moves bram_block 0->1, bram_addr 16383->0, with no gap cycle.

## Test plan
- Bank 1 preloaded with a pseudo-random pattern, FRAME_BITS=32768, pix_ready=1: 32768 bits match in order; first valid 4 cycles after start; pix_last only on bit 32767; done 1 cycle after it; bram_ce=10 throughout.
- Random pix_ready (50% duty) on bank 0: stream is bit-exact, no loss or duplication; inflight+fifo_count never exceeds 4.
- Block boundary: FRAME_BITS=16390, pix_ready=1: bram_block/bram_addr step 0/16383 -> 1/0 on consecutive cycles; bits from block 1 addresses 0..5 appear as indices 16384..16389.
- Start pulses at cycles 10 and 50 of a running frame with frame_bank toggled: ignored; frame completes from the original bank; a start the cycle after done begins a new frame.
- Reset asserted mid-FETCH with 3 bits buffered and pix_ready=0: all outputs return to reset values immediately; no done pulse; a following start scans from index 0.
- FRAME_BITS=1: exactly one handshake with pix_last=1, then done.
